mitchell_div_pipe: RTL
======================

# mitchell_div_pipe

Pipelined, approximate signed divider using Mitchell logarithmic arithmetic. It is the inverse companion of the team's 16x16 logarithmic multipliers: it divides a 32-bit product-width dividend by a 16-bit divisor and returns a 16-bit quotient. The block sits in the approximate-arithmetic datapath library and uses valid/ready handshakes on both sides.

## Interface

Parameters:
- `FRAC_W`, default 15: fraction width of the log mantissas. Legal range 15..24.

Ports:
- `clk`, input, 1: the single clock.
- `rst`, input, 1: reset, synchronous and active-high.
- `in_valid`, input, 1: the operand pair is valid.
- `in_ready`, output, 1: the block accepts a pair this cycle.
- `in_a`, input, 32: dividend, two's complement.
- `in_b`, input, 16: divisor, two's complement.
- `out_valid`, output, 1: the result is valid.
- `out_ready`, input, 1: the consumer accepts the result.
- `out_q`, output, 16: quotient, two's complement.
- `out_ovf`, output, 1: the quotient saturated.
- `out_dz`, output, 1: the divisor was zero.

## Operation

- **Magnitudes:** exact two's-complement absolute values. |a| is 32-bit unsigned, so -2^31 becomes 2^31. |b| is 16-bit unsigned. Result sign s = a[31] ^ b[15].
- **Leading one:**
  - ka is the leading-one position of |a| (0..31); kb is the leading-one position of |b| (0..15).
  - fa is the bits of |a| below the leading one, left-aligned into FRAC_W bits. Excess low bits are truncated; missing bits are zero-filled. fb is formed the same way.
- **Difference:** d = fa - fb, signed, FRAC_W+1 bits. e = ka - kb, signed, 7 bits.
  - If d >= 0: m = 2^FRAC_W + d, exponent e.
  - If d < 0: m = 2^(FRAC_W+1) + d, exponent e-1.
  - In both cases m lies in [2^FRAC_W, 2^(FRAC_W+1)).
- **Reconstruct:**
  - If exponent < 0: magnitude = 0.
  - If exponent >= 16: overflow.
  - Otherwise magnitude = (m << exponent) >> FRAC_W, truncating.
- **Saturation:**
  - s=0 and magnitude > 32767: q = 0x7FFF, ovf = 1.
  - s=1 and magnitude > 32768: q = 0x8000, ovf = 1.
  - Otherwise q = s ? -magnitude : magnitude.
- **Special cases:**
  - b = 0: dz = 1, ovf = 0. q = 0x8000 if a < 0, else 0x7FFF. This includes 0/0, which gives 0x7FFF.
  - a = 0 with b != 0: q = 0, both flags 0.

## Timing

- Three register stages:
  - S1: abs, LOD, normalize, special-case detect.
  - S2: difference and mantissa select.
  - S3: shift, saturate, sign, output registers.
- Latency: 3 cycles from the input handshake to `out_valid`. Throughput: 1 result per cycle.
- Global advance enable: en = ~out_valid | out_ready. `in_ready` = en, and is purely combinational from the output state.
- An input transfers when `in_valid & in_ready`. All stages shift when en is high. Bubbles travel as invalid slots and are not collapsed.
- While `out_valid & ~out_ready`:
  - `out_q`, `out_ovf`, `out_dz` hold stable.
  - Every stage holds.
  - `in_ready` = 0.
- Results leave in issue order; none are dropped or duplicated.
- Reset, including mid-operation: on the next edge all stage valids, `out_valid`, `out_q`, `out_ovf` and `out_dz` go to 0. In-flight operands are discarded. `in_ready` = 1 in the first cycle after reset.

## Structure

- Shared package `mitchell_pkg` holds:
  - Width constants: dividend 32, divisor 16, quotient 16, exponent width 7.
  - Saturation constants: Q_MAX = 0x7FFF, Q_MIN = 0x8000.
  - A struct for the S1/S2 stage payload: fa, fb, ka, kb, sign, flags.
- One sub-module, `mitchell_lod_norm`, parameterized by input width and FRAC_W. It outputs the leading-one position, the left-aligned fraction and a zero flag. It is instantiated twice (32-bit and 16-bit).

## Test plan

- a=1000, b=10 -> q=109 (0x006D), ovf=0, dz=0, 3 cycles after acceptance. This exercises the d >= 0 path.
- a=40, b=3 -> q=14. a=96, b=3 -> q=32. a=-4096, b=64 -> q=0xFFC0. These exercise the d < 0 path, the exact case and the sign path.
- a=0x40000000, b=1 -> q=0x7FFF, ovf=1. a=-32768, b=1 -> q=0x8000, ovf=0. a=0x80000000, b=1 -> q=0x8000, ovf=1.
- a=5, b=0 -> 0x7FFF, dz=1. a=-5, b=0 -> 0x8000, dz=1. a=0, b=0 -> 0x7FFF, dz=1. a=0, b=7 -> q=0, flags 0.
- Back-to-back 8 inputs, with `out_ready` held low for 5 cycles mid-stream -> `in_ready` drops, outputs hold stable, all 8 results arrive in order with no loss.
- Assert `rst` for one cycle with 2 operations in flight -> next cycle `out_valid`=0 and `out_q`=0. The discarded results never appear. A new input issued afterwards returns after 3 cycles.

Source files
------------

// File: rtl/mitchell_pkg.sv
// Shared constants and stage payload types for the Mitchell logarithmic divider.
// Fraction fields are sized for the widest legal FRAC_W; narrower builds leave the upper bits zero.
package mitchell_pkg;

  localparam int DIVIDEND_W = 32;
  localparam int DIVISOR_W  = 16;
  localparam int QUOT_W     = 16;
  localparam int EXP_W      = 7;
  localparam int KA_W       = 5;
  localparam int KB_W       = 4;
  localparam int FRAC_MAX   = 24;

  localparam logic [QUOT_W-1:0] Q_MAX = 16'h7FFF;
  localparam logic [QUOT_W-1:0] Q_MIN = 16'h8000;

  typedef struct packed {
    logic [FRAC_MAX-1:0] fa;
    logic [FRAC_MAX-1:0] fb;
    logic [KA_W-1:0]     ka;
    logic [KB_W-1:0]     kb;
    logic                sign;
    logic                a_neg;
    logic                dz;
    logic                az;
  } s1_pay_t;

  typedef struct packed {
    logic [FRAC_MAX:0]        m;
    logic signed [EXP_W-1:0]  ex;
    logic                     sign;
    logic                     a_neg;
    logic                     dz;
    logic                     az;
  } s2_pay_t;

endpackage

// File: rtl/mitchell_lod_norm.sv
// Leading-one detector plus normalizer: reports the leading-one position and the
// bits below it left-aligned into FRAC_W bits (truncated or zero-filled).
module mitchell_lod_norm #(
  parameter int IN_W   = 32,
  parameter int FRAC_W = 15
) (
  input  logic [IN_W-1:0]         x_i,
  output logic [$clog2(IN_W)-1:0] pos_o,
  output logic [FRAC_W-1:0]       frac_o,
  output logic                    zero_o
);

  localparam int POS_W = $clog2(IN_W);

  logic [IN_W+FRAC_W-1:0] wide;

  always_comb begin
    pos_o = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (x_i[i]) pos_o = POS_W'(i);
    end
  end

  // Shifting by IN_W-pos pushes the leading one out of the top, leaving the fraction MSB-first.
  assign wide   = {x_i, {FRAC_W{1'b0}}} << (IN_W - int'(pos_o));
  assign frac_o = FRAC_W'(wide >> IN_W);
  assign zero_o = (x_i == '0);

endmodule

// File: rtl/mitchell_div_pipe.sv
// Three-stage approximate signed divider (32/16 -> 16) using Mitchell log arithmetic.
// Handshake: a side transfers when valid & ready; all stages advance together when en = ~out_valid | out_ready.
module mitchell_div_pipe
  import mitchell_pkg::*;
#(
  parameter int FRAC_W = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] in_a,
  input  logic [DIVISOR_W-1:0]  in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [QUOT_W-1:0]     out_q,
  output logic                  out_ovf,
  output logic                  out_dz
);

  logic                  en;
  logic [DIVIDEND_W-1:0] a_abs;
  logic [DIVISOR_W-1:0]  b_abs;
  logic [KA_W-1:0]       ka;
  logic [KB_W-1:0]       kb;
  logic [FRAC_W-1:0]     fa, fb;
  logic                  a_zero, b_zero;

  s1_pay_t s1_d, s1_q;
  s2_pay_t s2_d, s2_q;
  logic    v1_q, v2_q, ov_q;

  logic [QUOT_W-1:0] q_d, q_q;
  logic              ovf_d, ovf_q, dz_d, dz_q;

  assign en       = ~ov_q | out_ready;
  assign in_ready = en;

  // ---------------- S1: magnitudes, leading one, special cases ----------------
  assign a_abs = in_a[DIVIDEND_W-1] ? (~in_a + 32'd1) : in_a;
  assign b_abs = in_b[DIVISOR_W-1]  ? (~in_b + 16'd1) : in_b;

  mitchell_lod_norm #(.IN_W(DIVIDEND_W), .FRAC_W(FRAC_W)) u_lod_a (
    .x_i(a_abs), .pos_o(ka), .frac_o(fa), .zero_o(a_zero)
  );

  mitchell_lod_norm #(.IN_W(DIVISOR_W), .FRAC_W(FRAC_W)) u_lod_b (
    .x_i(b_abs), .pos_o(kb), .frac_o(fb), .zero_o(b_zero)
  );

  always_comb begin
    s1_d       = '0;
    s1_d.fa    = FRAC_MAX'(fa);
    s1_d.fb    = FRAC_MAX'(fb);
    s1_d.ka    = ka;
    s1_d.kb    = kb;
    s1_d.sign  = in_a[DIVIDEND_W-1] ^ in_b[DIVISOR_W-1];
    s1_d.a_neg = in_a[DIVIDEND_W-1];
    s1_d.dz    = b_zero;
    s1_d.az    = a_zero;
  end

  // ---------------- S2: log difference and mantissa select ----------------
  logic [FRAC_MAX:0]       d_full;
  logic signed [EXP_W-1:0] e_raw;

  always_comb begin
    s2_d       = '0;
    d_full     = {1'b0, s1_q.fa} - {1'b0, s1_q.fb};
    e_raw      = $signed(EXP_W'(s1_q.ka)) - $signed(EXP_W'(s1_q.kb));
    // A negative difference borrows one from the exponent: m = 2^(F+1) + d, else 2^F + d.
    if (d_full[FRAC_MAX]) begin
      s2_d.m  = d_full + (FRAC_MAX+1)'(2) ** (FRAC_W+1);
      s2_d.ex = e_raw - 7'sd1;
    end else begin
      s2_d.m  = d_full + (FRAC_MAX+1)'(2) ** FRAC_W;
      s2_d.ex = e_raw;
    end
    s2_d.sign  = s1_q.sign;
    s2_d.a_neg = s1_q.a_neg;
    s2_d.dz    = s1_q.dz;
    s2_d.az    = s1_q.az;
  end

  // ---------------- S3: antilog shift, saturation, sign ----------------
  logic [FRAC_MAX+16:0] w;
  logic [QUOT_W-1:0]    mag;
  logic                 big;

  always_comb begin
    w     = (FRAC_MAX+17)'(s2_q.m) << s2_q.ex[3:0];
    mag   = 16'(w >> FRAC_W);
    big   = 1'b0;
    q_d   = '0;
    ovf_d = 1'b0;
    dz_d  = 1'b0;
    if (s2_q.ex < 7'sd0) mag = '0;
    else if (s2_q.ex > 7'sd15) big = 1'b1;

    if (s2_q.dz) begin
      q_d  = s2_q.a_neg ? Q_MIN : Q_MAX;
      dz_d = 1'b1;
    end else if (s2_q.az) begin
      q_d = '0;
    end else if (big || (!s2_q.sign && mag > 16'd32767) || (s2_q.sign && mag > 16'd32768)) begin
      q_d   = s2_q.sign ? Q_MIN : Q_MAX;
      ovf_d = 1'b1;
    end else begin
      q_d = s2_q.sign ? (~mag + 16'd1) : mag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      ov_q  <= 1'b0;
      s1_q  <= '0;
      s2_q  <= '0;
      q_q   <= '0;
      ovf_q <= 1'b0;
      dz_q  <= 1'b0;
    end else if (en) begin
      v1_q <= in_valid;
      s1_q <= s1_d;
      v2_q <= v1_q;
      s2_q <= s2_d;
      ov_q <= v2_q;
      if (v2_q) begin
        q_q   <= q_d;
        ovf_q <= ovf_d;
        dz_q  <= dz_d;
      end
    end
  end

  assign out_valid = ov_q;
  assign out_q     = q_q;
  assign out_ovf   = ovf_q;
  assign out_dz    = dz_q;

endmodule
